// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core/memory arbiter: op encodings, FSM states
// and default widths. Package name mem_arb_defs.
package mem_arb_defs;

    localparam int unsigned DEF_NUM_CORES = 4;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ADDR_W    = 10;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LD   = 2'b01;
    localparam logic [1:0] OP_ST   = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // 2'b11 is deliberately treated the same as no request
    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/core_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_CORES.
module rr_picker #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_CORES);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter funnelling per-core LD/ST requests onto one memory port.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module core_mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NUM_CORES-1:0]        core_enable,
    input  logic [ADDR_W*NUM_CORES-1:0]   core_addr,
    input  logic [DATA_W*NUM_CORES-1:0]   core_wr_data,
    output logic [NUM_CORES-1:0]          core_ready,
    output logic [DATA_W-1:0]             core_rd_data,
    output logic [1:0]                    mem_enable,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wr_data,
    input  logic [DATA_W-1:0]             mem_rd_data,
    input  logic                          mem_ready,
    output logic [15:0]                   stat_access,
    output logic [15:0]                   stat_contention
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_CORES-1:0] req_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    always_comb begin
        req_vld = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            req_vld[i] = op_valid(core_enable[2*i +: 2]);
        end
    end

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req         (req_vld),
        .ptr         (rr_ptr_q),
        .grant_idx   (pick_idx),
        .grant_valid (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d  = ACCESS;
                    winner_d = pick_idx;
                    // constant-index mux keeps the part selects static
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        if (pick_idx == IDX_W'(i)) begin
                            op_d    = core_enable[2*i +: 2];
                            addr_d  = core_addr[ADDR_W*i +: ADDR_W];
                            wdata_d = core_wr_data[DATA_W*i +: DATA_W];
                        end
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    rdata_d = mem_rd_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d  = IDLE;
                rr_ptr_d = (winner_q == IDX_W'(NUM_CORES - 1)) ? '0 : winner_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            op_q     <= OP_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        core_ready = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_ready[i] = (state_q == RESP) && (winner_q == IDX_W'(i));
        end
        mem_enable   = (state_q == ACCESS) ? op_q : OP_NONE;
        mem_addr     = addr_q;
        mem_wr_data  = wdata_q;
        core_rd_data = rdata_q;
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0]  stat_access_q, stat_access_d;
    logic [15:0]  stat_contention_q, stat_contention_d;
    int unsigned  req_cnt;

    always_comb begin
        req_cnt = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            req_cnt = req_cnt + 32'(req_vld[i]);
        end
        stat_access_d     = stat_access_q;
        stat_contention_d = stat_contention_q;
        if ((state_q == RESP) && (stat_access_q != '1)) begin
            stat_access_d = stat_access_q + 16'd1;
        end
        if ((req_cnt >= 2) && (stat_contention_q != '1)) begin
            stat_contention_d = stat_contention_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_access_q     <= '0;
            stat_contention_q <= '0;
        end else begin
            stat_access_q     <= stat_access_d;
            stat_contention_q <= stat_contention_d;
        end
    end

    assign stat_access     = stat_access_q;
    assign stat_contention = stat_contention_q;
`else
    assign stat_access     = '0;
    assign stat_contention = '0;
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized self-checking bench for core_mem_arbiter against a
// transaction-level round-robin model with a behavioural memory.
module tb_core_mem_arbiter;
    import mem_arb_defs::*;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [2*NC-1:0]   core_enable;
    logic [AW*NC-1:0]  core_addr;
    logic [DW*NC-1:0]  core_wr_data;
    logic [NC-1:0]     core_ready;
    logic [DW-1:0]     core_rd_data;
    logic [1:0]        mem_enable;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wr_data;
    logic [DW-1:0]     mem_rd_data;
    logic              mem_ready;
    logic [15:0]       stat_access;
    logic [15:0]       stat_contention;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .NUM_CORES (NC),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .core_enable     (core_enable),
        .core_addr       (core_addr),
        .core_wr_data    (core_wr_data),
        .core_ready      (core_ready),
        .core_rd_data    (core_rd_data),
        .mem_enable      (mem_enable),
        .mem_addr        (mem_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_rd_data     (mem_rd_data),
        .mem_ready       (mem_ready),
        .stat_access     (stat_access),
        .stat_contention (stat_contention)
    );

    // behavioural shared memory
    logic [DW-1:0] mem_arr [1 << AW];
    assign mem_rd_data = mem_arr[mem_addr];

    // per-core request table and model state
    logic [1:0]    r_op   [NC];
    logic [AW-1:0] r_addr [NC];
    logic [DW-1:0] r_data [NC];
    logic [1:0]    idle_op[NC];
    bit            pend   [NC];
    int            m_ptr, m_acc, m_cont;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NC; i++) begin
            core_enable[2*i +: 2]    = pend[i] ? r_op[i] : idle_op[i];
            core_addr[AW*i +: AW]    = r_addr[i];
            core_wr_data[DW*i +: DW] = r_data[i];
        end
    endtask

    task automatic tick();
        int n;
        n = 0;
        for (int i = 0; i < NC; i++) if (pend[i]) n++;
        if (!reset && n >= 2) m_cont++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef MEM_ARB_STATS_EN
        check_eq({tag, "_stat_access"}, 32'(stat_access), 32'(m_acc));
        check_eq({tag, "_stat_contention"}, 32'(stat_contention), 32'(m_cont));
`else
        check_eq({tag, "_stat_access"}, 32'(stat_access), 32'd0);
        check_eq({tag, "_stat_contention"}, 32'(stat_contention), 32'd0);
`endif
    endtask

    // Serve all pending requests; expected grant order from round-robin over the pending set.
    task automatic run_round(input string tag, input int stall_n);
        int        order[$];
        bit        tmp[NC];
        int        p, cyc, act, w;
        bit        first;
        logic [DW-1:0] exp_rd;
        tmp = pend;
        p   = m_ptr;
        for (int k = 0; k < NC; k++) begin
            for (int j = 0; j < NC; j++) begin
                int c;
                c = (p + j) % NC;
                if (tmp[c]) begin
                    order.push_back(c);
                    tmp[c] = 0;
                    p = (c + 1) % NC;
                    break;
                end
            end
        end
        apply_inputs();
        cyc = 0; act = 0; first = 1; exp_rd = '0;
        while (order.size() > 0 && cyc < 300) begin
            w = order[0];
            if (core_ready != '0) begin
                check_eq({tag, "_ready"}, 32'(core_ready), 32'(1 << w));
                check_eq({tag, "_mem_en_resp"}, 32'(mem_enable), 32'(OP_NONE));
                check_eq({tag, "_access_cycles"}, 32'(act), 32'(stall_n + 1));
                if (r_op[w] == OP_LD) check_eq({tag, "_rd_data"}, 32'(core_rd_data), 32'(exp_rd));
                if (first) check_eq({tag, "_latency"}, 32'(cyc), 32'(stall_n + 2));
                first = 0;
                void'(order.pop_front());
                pend[w] = 0;
                m_acc++;
                m_ptr = (w + 1) % NC;
                act = 0;
                apply_inputs();
            end else if (mem_enable != OP_NONE) begin
                check_eq({tag, "_mem_en"}, 32'(mem_enable), 32'(r_op[w]));
                check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'(r_addr[w]));
                if (r_op[w] == OP_ST) check_eq({tag, "_mem_wdata"}, 32'(mem_wr_data), 32'(r_data[w]));
                act++;
                mem_ready = (act > stall_n);
                if (mem_ready) begin
                    if (r_op[w] == OP_LD) exp_rd = mem_arr[r_addr[w]];
                    else mem_arr[r_addr[w]] = r_data[w];
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        if (order.size() > 0) check_eq({tag, "_timeout"}, 32'(order.size()), 32'd0);
        tick();
        check_stats(tag);
    endtask

    task automatic set_req(input int c, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[c] = 1; r_op[c] = op; r_addr[c] = a; r_data[c] = d;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 8'($urandom);
        for (int i = 0; i < NC; i++) begin
            pend[i] = 0; r_op[i] = OP_NONE; r_addr[i] = '0; r_data[i] = '0; idle_op[i] = OP_NONE;
        end
        m_ptr = 0; m_acc = 0; m_cont = 0;
        reset = 1'b1; mem_ready = 1'b0;
        apply_inputs();
        tick();
        tick();
        check_eq("rst_core_ready", 32'(core_ready), 32'd0);
        check_eq("rst_rd_data", 32'(core_rd_data), 32'd0);
        check_eq("rst_mem_en", 32'(mem_enable), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wr_data), 32'd0);
        reset = 1'b0;
        check_stats("rst");

        // all four cores store at once from rr_ptr 0
        for (int i = 0; i < NC; i++) set_req(i, OP_ST, AW'((i << 8) | (16 + i)), DW'(8'hA0 + i));
        run_round("st_all", 0);

        // single load from core 2
        mem_arr[10'h2A5] = 8'h5C;
        set_req(2, OP_LD, 10'h2A5, 8'h00);
        run_round("ld_single", 0);
        check_eq("ld_single_data_hold", 32'(core_rd_data), 32'h5C);

        // memory stall of 5 cycles
        set_req(1, OP_LD, 10'h133, 8'h00);
        run_round("stall", 5);

        // 2'b11 everywhere is not a request
        for (int i = 0; i < NC; i++) idle_op[i] = 2'b11;
        apply_inputs();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("inv_mem_en", 32'(mem_enable), 32'd0);
            check_eq("inv_ready", 32'(core_ready), 32'd0);
        end
        for (int i = 0; i < NC; i++) idle_op[i] = OP_NONE;
        apply_inputs();
        tick();

        // three cores contending
        set_req(0, OP_LD, 10'h011, 8'h00);
        set_req(1, OP_ST, 10'h122, 8'h77);
        set_req(3, OP_LD, 10'h122 ^ 10'h200, 8'h00);
        run_round("contend", 0);

        // randomized rounds
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NC; i++) begin
                idle_op[i] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                if ($urandom_range(0, 2) != 0)
                    set_req(i, $urandom_range(0, 1) ? OP_ST : OP_LD,
                            AW'((i << 8) | $urandom_range(0, 255)), DW'($urandom));
            end
            run_round("rand", int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < NC; i++) idle_op[i] = OP_NONE;

        // reset during ACCESS: ptr moved to 2 first, so core 3 wins before reset
        mem_arr[10'h155] = 8'hA7;
        set_req(1, OP_LD, 10'h155, 8'h00);
        run_round("pre_rst", 0);
        set_req(0, OP_ST, 10'h0F0, 8'h3C);
        set_req(3, OP_ST, 10'h30F, 8'hC3);
        apply_inputs();
        mem_ready = 1'b0;
        tick();
        check_eq("rst_acc_mem_en", 32'(mem_enable), 32'(OP_ST));
        check_eq("rst_acc_mem_addr", 32'(mem_addr), 32'h30F);
        reset = 1'b1;
        #1;
        check_eq("rst_acc_mem_en0", 32'(mem_enable), 32'd0);
        check_eq("rst_acc_addr0", 32'(mem_addr), 32'd0);
        check_eq("rst_acc_wdata0", 32'(mem_wr_data), 32'd0);
        check_eq("rst_acc_rd0", 32'(core_rd_data), 32'd0);
        m_ptr = 0; m_acc = 0; m_cont = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("rst_acc_ready", 32'(core_ready), 32'd0);
        end
        reset = 1'b0;
        run_round("post_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
